// File: rtl/pll_cfg_seq.sv
// ---------------------------------------------------------------------------
// pll_cfg_seq
//
// Initiator-side sequencer for the Cyclone V PLL reconfiguration management
// port. On request it writes a new N/M/C0/C1 counter set into the
// reconfiguration controller. It then triggers the update, polls the
// controller's status register until it reports completion, and waits for a
// stable PLL lock.
//
// Ports:
//   clk, rst          management clock, asynchronous active-high reset
//   req               start a reconfiguration (sampled only while idle)
//   cfg_n/m/c0/c1     18-bit counter settings {odd, bypass, hi[7:0], lo[7:0]}
//   busy, done, err   status: busy level, done pulse, error pulse
//   mgmt_*            Avalon-MM style management master
//   pll_locked        PLL lock, already synchronised to clk
//
// All outputs are registered. They are decoded from the next state, so they
// line up with the state register.
// ---------------------------------------------------------------------------
module pll_cfg_seq #(
  parameter int unsigned POLL_MAX     = 255,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned LOCK_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [17:0] cfg_n,
  input  logic [17:0] cfg_m,
  input  logic [17:0] cfg_c0,
  input  logic [17:0] cfg_c1,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic        mgmt_read,
  output logic [31:0] mgmt_writedata,
  input  logic [31:0] mgmt_readdata,
  input  logic        mgmt_waitrequest,
  input  logic        pll_locked
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_W_MODE   = 4'd1;
  localparam logic [3:0] S_W_N      = 4'd2;
  localparam logic [3:0] S_W_M      = 4'd3;
  localparam logic [3:0] S_W_C0     = 4'd4;
  localparam logic [3:0] S_W_C1     = 4'd5;
  localparam logic [3:0] S_W_START  = 4'd6;
  localparam logic [3:0] S_POLL_RD  = 4'd7;
  localparam logic [3:0] S_POLL_GAP = 4'd8;
  localparam logic [3:0] S_LOCK     = 4'd9;
  localparam logic [3:0] S_DONE     = 4'd10;
  localparam logic [3:0] S_ERR      = 4'd11;

  localparam int unsigned POLL_W = $clog2(POLL_MAX + 1);
  localparam int unsigned STAB_W = $clog2(LOCK_STABLE + 1);
  localparam int unsigned TMO_W  = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [POLL_W-1:0] POLL_LIMIT  = POLL_W'(POLL_MAX);
  localparam logic [STAB_W-1:0] STABLE_LAST = STAB_W'(LOCK_STABLE - 1);
  localparam logic [TMO_W-1:0]  TMO_LIMIT   = TMO_W'(LOCK_TIMEOUT);

  logic [3:0]        state_q, state_d;
  logic [17:0]       n_q, n_d, m_q, m_d, c0_q, c0_d, c1_q, c1_d;
  logic [POLL_W-1:0] pollCnt_q, pollCnt_d, pollInc;
  logic [STAB_W-1:0] stableCnt_q, stableCnt_d, stableInc;
  logic [TMO_W-1:0]  tmoCnt_q, tmoCnt_d, tmoInc;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [5:0]        addr_q, addr_d;
  logic              write_q, write_d;
  logic              read_q, read_d;
  logic [31:0]       wdata_q, wdata_d;

  // Only the completion flag of the status word matters to the sequencer.
  logic              unusedReadBits;
  assign unusedReadBits = ^mgmt_readdata[31:1];

  // Saturating increments, so no counter can ever wrap.
  assign pollInc   = (pollCnt_q == '1)   ? pollCnt_q   : pollCnt_q + POLL_W'(1);
  assign stableInc = (stableCnt_q == '1) ? stableCnt_q : stableCnt_q + STAB_W'(1);
  assign tmoInc    = (tmoCnt_q == '1)    ? tmoCnt_q    : tmoCnt_q + TMO_W'(1);

  // Next-state logic. A strobe is high exactly when the state is a bus
  // state, so "waitrequest low" alone marks the end of a transfer there.
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    m_d         = m_q;
    c0_d        = c0_q;
    c1_d        = c1_q;
    pollCnt_d   = pollCnt_q;
    stableCnt_d = stableCnt_q;
    tmoCnt_d    = tmoCnt_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_W_MODE;
          n_d     = cfg_n;
          m_d     = cfg_m;
          c0_d    = cfg_c0;
          c1_d    = cfg_c1;
        end
      end
      S_W_MODE:  if (!mgmt_waitrequest) state_d = S_W_N;
      S_W_N:     if (!mgmt_waitrequest) state_d = S_W_M;
      S_W_M:     if (!mgmt_waitrequest) state_d = S_W_C0;
      S_W_C0:    if (!mgmt_waitrequest) state_d = S_W_C1;
      S_W_C1:    if (!mgmt_waitrequest) state_d = S_W_START;
      S_W_START: begin
        if (!mgmt_waitrequest) begin
          state_d   = S_POLL_RD;
          pollCnt_d = '0;
        end
      end
      S_POLL_RD: begin
        if (!mgmt_waitrequest) begin
          if (mgmt_readdata[0]) begin
            state_d     = S_LOCK;
            stableCnt_d = '0;
            tmoCnt_d    = '0;
          end else begin
            pollCnt_d = pollInc;
            state_d   = (pollInc >= POLL_LIMIT) ? S_ERR : S_POLL_GAP;
          end
        end
      end
      S_POLL_GAP: state_d = S_POLL_RD;
      S_LOCK: begin
        // The timeout test uses the incremented value. LOCK therefore lasts
        // at most LOCK_TIMEOUT cycles. A completed stable window takes
        // priority over a simultaneous timeout.
        stableCnt_d = pll_locked ? stableInc : '0;
        tmoCnt_d    = tmoInc;
        if (pll_locked && (stableCnt_q == STABLE_LAST)) begin
          state_d = S_DONE;
        end else if (tmoInc >= TMO_LIMIT) begin
          state_d = S_ERR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state. The registered outputs then hold the
  // address and data of the state being entered, stable for as long as
  // waitrequest stalls it.
  always_comb begin
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    err_d   = (state_d == S_ERR);
    write_d = 1'b0;
    read_d  = 1'b0;
    addr_d  = 6'd0;
    wdata_d = 32'd0;
    case (state_d)
      S_W_MODE: begin
        write_d = 1'b1;
        addr_d  = 6'd0;
        wdata_d = 32'd1;
      end
      S_W_N: begin
        write_d = 1'b1;
        addr_d  = 6'd3;
        wdata_d = {14'b0, n_d};
      end
      S_W_M: begin
        write_d = 1'b1;
        addr_d  = 6'd4;
        wdata_d = {14'b0, m_d};
      end
      S_W_C0: begin
        write_d = 1'b1;
        addr_d  = 6'd5;
        wdata_d = {9'b0, 5'd0, c0_d};
      end
      S_W_C1: begin
        write_d = 1'b1;
        addr_d  = 6'd5;
        wdata_d = {9'b0, 5'd1, c1_d};
      end
      S_W_START: begin
        write_d = 1'b1;
        addr_d  = 6'd2;
        wdata_d = 32'd0;
      end
      S_POLL_RD: begin
        read_d = 1'b1;
        addr_d = 6'd1;
      end
      default: begin
        write_d = 1'b0;
        read_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      m_q         <= '0;
      c0_q        <= '0;
      c1_q        <= '0;
      pollCnt_q   <= '0;
      stableCnt_q <= '0;
      tmoCnt_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      read_q      <= 1'b0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      m_q         <= m_d;
      c0_q        <= c0_d;
      c1_q        <= c1_d;
      pollCnt_q   <= pollCnt_d;
      stableCnt_q <= stableCnt_d;
      tmoCnt_q    <= tmoCnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      read_q      <= read_d;
      wdata_q     <= wdata_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign mgmt_address   = addr_q;
  assign mgmt_write     = write_q;
  assign mgmt_read      = read_q;
  assign mgmt_writedata = wdata_q;

endmodule

// File: tb/tb_pll_cfg_seq.sv
// ---------------------------------------------------------------------------
// tb_pll_cfg_seq
//
// Directed bench for pll_cfg_seq. A small management-port responder drives
// waitrequest and logs every completed transfer. Each scenario compares the
// transfer log and the req-to-done/err latency against hand-computed values.
// ---------------------------------------------------------------------------
module tb_pll_cfg_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [17:0] cfg_n, cfg_m, cfg_c0, cfg_c1;
  logic        busy, done, err;
  logic [5:0]  mgmt_address;
  logic        mgmt_write, mgmt_read;
  logic [31:0] mgmt_writedata;
  logic [31:0] mgmt_readdata;
  logic        mgmt_waitrequest = 1'b0;
  logic        pll_locked;

  int testsRun    = 0;
  int testsFailed = 0;

  // Responder configuration and state
  logic        statusBit   = 1'b1;
  int          stallWrAddr = -1;
  int          stallWrCnt  = 0;
  int          stallRdCnt  = 0;
  int          stallLeft   = 0;
  bit          pending     = 1'b0;
  logic [5:0]  holdAddr    = '0;
  logic [31:0] holdData    = '0;
  int          unstable    = 0;
  int          doneCycles  = 0;
  int          errCycles   = 0;
  int          negCount    = 0;

  logic [5:0]  logAddr[$];
  logic [31:0] logData[$];
  bit          logRd[$];
  int          logStamp[$];

  pll_cfg_seq #(
    .POLL_MAX     (4),
    .LOCK_STABLE  (1024),
    .LOCK_TIMEOUT (65535)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req              (req),
    .cfg_n            (cfg_n),
    .cfg_m            (cfg_m),
    .cfg_c0           (cfg_c0),
    .cfg_c1           (cfg_c1),
    .busy             (busy),
    .done             (done),
    .err              (err),
    .mgmt_address     (mgmt_address),
    .mgmt_write       (mgmt_write),
    .mgmt_read        (mgmt_read),
    .mgmt_writedata   (mgmt_writedata),
    .mgmt_readdata    (mgmt_readdata),
    .mgmt_waitrequest (mgmt_waitrequest),
    .pll_locked       (pll_locked)
  );

  always #5 clk = ~clk;

  assign mgmt_readdata = {31'b0, statusBit};

  // Management responder, evaluated mid-cycle. It decides waitrequest for
  // the current cycle and logs a transfer that will complete on the next
  // rising edge. It also flags address/data changes during a stall and any
  // overlap of the two strobes.
  always @(negedge clk) begin
    negCount++;
    if (done) doneCycles++;
    if (err) errCycles++;
    if (mgmt_write && mgmt_read) unstable++;
    if (mgmt_write || mgmt_read) begin
      if (!pending) begin
        holdAddr = mgmt_address;
        holdData = mgmt_writedata;
        if (mgmt_read) stallLeft = stallRdCnt;
        else if (int'(mgmt_address) == stallWrAddr) stallLeft = stallWrCnt;
        else stallLeft = 0;
      end else if (mgmt_address != holdAddr || mgmt_writedata != holdData) begin
        unstable++;
      end
      if (stallLeft > 0) begin
        stallLeft--;
        pending = 1'b1;
        mgmt_waitrequest = 1'b1;
      end else begin
        pending = 1'b0;
        mgmt_waitrequest = 1'b0;
        logAddr.push_back(mgmt_address);
        logData.push_back(mgmt_writedata);
        logRd.push_back(mgmt_read);
        logStamp.push_back(negCount);
      end
    end else begin
      pending = 1'b0;
      mgmt_waitrequest = 1'b0;
    end
  end

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic clearLogs();
    logAddr.delete();
    logData.delete();
    logRd.delete();
    logStamp.delete();
    doneCycles = 0;
    errCycles  = 0;
    unstable   = 0;
  endtask

  // Present a request with the given counter set at a falling edge
  task automatic applyStimulus(input logic [17:0] n, input logic [17:0] m,
                               input logic [17:0] c0, input logic [17:0] c1);
    @(negedge clk);
    cfg_n  = n;
    cfg_m  = m;
    cfg_c0 = c0;
    cfg_c1 = c1;
    req    = 1'b1;
  endtask

  // Count rising edges (the one that samples req is edge 1) until done or
  // err shows up. After the accepting edge, drop req and scramble cfg_* to
  // prove they were latched. An optional one-cycle lock drop is placed after
  // edge glitchAt.
  task automatic waitForEnd(input int limit, input int glitchAt, output int cycles,
                            output bit sawDone, output bit sawErr, output logic [7:0] firstSnap);
    cycles    = 0;
    sawDone   = 1'b0;
    sawErr    = 1'b0;
    firstSnap = '0;
    while (cycles < limit && !sawDone && !sawErr) begin
      @(posedge clk);
      #1;
      cycles++;
      if (cycles == 1) begin
        firstSnap = {busy, mgmt_write, mgmt_address};
        req    = 1'b0;
        cfg_n  = '1;
        cfg_m  = '1;
        cfg_c0 = '1;
        cfg_c1 = '1;
      end
      if (cycles == glitchAt) pll_locked = 1'b0;
      if (cycles == glitchAt + 1) pll_locked = 1'b1;
      sawDone = done;
      sawErr  = err;
    end
  endtask

  // Compare the transfer log with the full write/write/.../read sequence
  task automatic checkSequence(input string tag, input logic [31:0] dn, input logic [31:0] dm,
                               input logic [31:0] dc0, input logic [31:0] dc1);
    logic [5:0]  expAddr [0:6];
    logic [31:0] expData [0:5];
    expAddr = '{6'd0, 6'd3, 6'd4, 6'd5, 6'd5, 6'd2, 6'd1};
    expData = '{32'd1, dn, dm, dc0, dc1, 32'd0};
    checkOutput({tag, " xfer count"}, 64'(logAddr.size()), 64'd7);
    for (int i = 0; i < logAddr.size() && i < 7; i++) begin
      checkOutput($sformatf("%s addr%0d", tag, i), 64'(logAddr[i]), 64'(expAddr[i]));
      checkOutput($sformatf("%s kind%0d", tag, i), 64'(logRd[i]), 64'(i == 6));
      if (i < 6) checkOutput($sformatf("%s data%0d", tag, i), 64'(logData[i]), 64'(expData[i]));
    end
  endtask

  initial begin
    int          cycles;
    bit          sawDone, sawErr;
    logic [7:0]  firstSnap;
    bit          found;
    int          readCount;

    rst        = 1'b1;
    req        = 1'b0;
    cfg_n      = '0;
    cfg_m      = '0;
    cfg_c0     = '0;
    cfg_c1     = '0;
    pll_locked = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset outputs", 64'({busy, done, err, mgmt_write, mgmt_read, mgmt_address, mgmt_writedata}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Zero-wait happy path
    $display("[TB] happy path");
    clearLogs();
    applyStimulus(18'h20302, 18'h01818, 18'h00505, 18'h20302);
    waitForEnd(2000, -1, cycles, sawDone, sawErr, firstSnap);
    checkOutput("happy first cycle", 64'(firstSnap), 64'h80 | 64'h40);
    checkOutput("happy done seen", 64'(sawDone), 64'd1);
    checkOutput("happy latency", 64'(cycles), 64'd1032);
    checkSequence("happy", 32'h20302, 32'h01818, 32'h0000505, 32'h0060302);
    @(posedge clk);
    #1;
    checkOutput("happy busy after done", 64'({busy, done}), 64'd0);
    checkOutput("happy done pulses", 64'(doneCycles), 64'd1);

    // Waitrequest stress: 3 stalls on the M write, 2 on the status read
    $display("[TB] waitrequest stress");
    clearLogs();
    stallWrAddr = 4;
    stallWrCnt  = 3;
    stallRdCnt  = 2;
    applyStimulus(18'h20302, 18'h01818, 18'h00505, 18'h20302);
    waitForEnd(2000, -1, cycles, sawDone, sawErr, firstSnap);
    checkOutput("stress latency", 64'(cycles), 64'd1037);
    checkSequence("stress", 32'h20302, 32'h01818, 32'h0000505, 32'h0060302);
    checkOutput("stress stability", 64'(unstable), 64'd0);
    stallWrAddr = -1;
    stallWrCnt  = 0;
    stallRdCnt  = 0;
    @(posedge clk);

    // Poll timeout with status never set (POLL_MAX = 4)
    $display("[TB] poll timeout");
    clearLogs();
    statusBit = 1'b0;
    applyStimulus(18'h00101, 18'h00202, 18'h00303, 18'h00404);
    waitForEnd(200, -1, cycles, sawDone, sawErr, firstSnap);
    checkOutput("poll err seen", 64'(sawErr), 64'd1);
    checkOutput("poll err latency", 64'(cycles), 64'd14);
    readCount = 0;
    foreach (logRd[i]) if (logRd[i]) readCount++;
    checkOutput("poll read count", 64'(readCount), 64'd4);
    for (int i = 7; i < logStamp.size(); i++)
      checkOutput($sformatf("poll gap%0d", i), 64'(logStamp[i] - logStamp[i-1]), 64'd2);
    @(posedge clk);
    #1;
    checkOutput("poll err pulses", 64'(errCycles), 64'd1);
    checkOutput("poll no done", 64'(doneCycles), 64'd0);
    checkOutput("poll busy after err", 64'(busy), 64'd0);
    statusBit = 1'b1;

    // Lock glitch during stable count 500 restarts the stable window
    $display("[TB] lock glitch");
    clearLogs();
    applyStimulus(18'h20302, 18'h01818, 18'h00505, 18'h20302);
    waitForEnd(3000, 508, cycles, sawDone, sawErr, firstSnap);
    checkOutput("glitch done seen", 64'(sawDone), 64'd1);
    checkOutput("glitch latency", 64'(cycles), 64'd1533);
    @(posedge clk);

    // Lock never arrives: err after 65535 cycles in LOCK
    $display("[TB] lock timeout");
    clearLogs();
    pll_locked = 1'b0;
    applyStimulus(18'h20302, 18'h01818, 18'h00505, 18'h20302);
    waitForEnd(70000, -1, cycles, sawDone, sawErr, firstSnap);
    checkOutput("lock err seen", 64'(sawErr), 64'd1);
    checkOutput("lock timeout latency", 64'(cycles), 64'd65543);
    checkOutput("lock no done", 64'(doneCycles), 64'd0);
    pll_locked = 1'b1;
    @(posedge clk);

    // Stray req while busy, then async reset in the middle of the C0 write
    $display("[TB] reset mid-sequence");
    clearLogs();
    stallWrAddr = 5;
    stallWrCnt  = 20;
    applyStimulus(18'h20302, 18'h01818, 18'h00505, 18'h20302);
    @(posedge clk);
    #1;
    req = 1'b0;
    @(negedge clk);
    req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (mgmt_write && mgmt_address == 6'd5) found = 1'b1;
    end
    checkOutput("reach C0 write", 64'(found), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async reset outputs", 64'({busy, done, err, mgmt_write, mgmt_read, mgmt_address, mgmt_writedata}), 64'd0);
    checkOutput("no restart xfers", 64'(logAddr.size()), 64'd3);
    if (logAddr.size() == 3) checkOutput("no restart order", 64'(logAddr[2]), 64'd4);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    stallWrAddr = -1;
    stallWrCnt  = 0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("idle after reset", 64'({busy, mgmt_write, mgmt_read}), 64'd0);
    checkOutput("no bus after reset", 64'(logAddr.size()), 64'd3);

    clearLogs();
    applyStimulus(18'h00101, 18'h10A0B, 18'h3FFFF, 18'h00000);
    waitForEnd(2000, -1, cycles, sawDone, sawErr, firstSnap);
    checkOutput("rerun latency", 64'(cycles), 64'd1032);
    checkSequence("rerun", 32'h00101, 32'h10A0B, 32'h003FFFF, 32'h0040000);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
